// File: rtl/ysyx_25020037_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020037_lsu_pkg
// Description : Shared encodings for the load/store stage: access sizes and
//               controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25020037_lsu_pkg;

  // Access size encoding carried on in_lsize / in_ssize
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_t;

  // True when an access of the given size cannot be issued at this byte lane
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25020037_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020037_lsu_align
// Description : Combinational byte-lane logic for the load/store stage.
//               Request side: alignment check, store strobes and lane
//               replication. Response side: lane select and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  // request side (driven from the incoming op)
  input  logic        req_is_write,
  input  logic [1:0]  req_lsize,
  input  logic [1:0]  req_ssize,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_wdata,
  output logic        req_misaligned,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata_lanes,
  // response side (driven from the captured op)
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [1:0]  req_size;
  logic [31:0] ld_shifted;
  logic        ld_sign;

  // A store (even with the read flag also set) is checked against its store size
  assign req_size       = req_is_write ? req_ssize : req_lsize;
  assign req_misaligned = is_misaligned(req_size, req_lane);

  // Store strobes and lane replication; the memory picks bytes via the strobes
  always_comb begin
    req_wstrb       = 4'b0000;
    req_wdata_lanes = req_wdata;
    case (req_ssize)
      SZ_B: begin
        req_wstrb       = 4'b0001 << req_lane;
        req_wdata_lanes = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        req_wstrb       = 4'b0011 << req_lane;
        req_wdata_lanes = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        req_wstrb       = 4'b1111;
        req_wdata_lanes = req_wdata;
      end
      default: begin
        req_wstrb       = 4'b0000;
        req_wdata_lanes = req_wdata;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then sign- or zero-extend by size
  always_comb begin
    ld_shifted = ld_rdata >> {ld_lane, 3'b000};
    ld_sign    = 1'b0;
    ld_value   = ld_shifted;
    case (ld_size)
      SZ_B: begin
        ld_sign  = !ld_unsigned && ld_shifted[7];
        ld_value = {{24{ld_sign}}, ld_shifted[7:0]};
      end
      SZ_H: begin
        ld_sign  = !ld_unsigned && ld_shifted[15];
        ld_value = {{16{ld_sign}}, ld_shifted[15:0]};
      end
      default: ld_value = ld_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_25020037_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25020037_lsu_stage
// Description : Load/store stage. Accepts one op per handshake, keeps at most
//               one data-memory request outstanding, guards it with a
//               response watchdog and hands results to write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020037_lsu_stage
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic [31:0]       in_pc,
  input  logic [3:0]        in_rd,
  input  logic              in_gpr_we,
  input  logic              in_is_read,
  input  logic              in_is_write,
  input  logic [1:0]        in_lsize,
  input  logic [1:0]        in_ssize,
  input  logic              in_unsigned,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [DATA_W-1:0] rdata_processed,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp_err,
  output logic              lsu_valid,
  input  logic              wbu_ready,
  output logic [31:0]       lsu_pc,
  output logic [3:0]        lsu_rd,
  output logic              lsu_gpr_we,
  output logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_fault
);

  // Watchdog counts 0 .. TIMEOUT_CYCLES-1 inside WAIT
  localparam int            WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t       state;
  logic [WD_W-1:0]  wd_cnt;

  // op fields captured at acceptance for use when the response returns
  logic [31:0]       op_pc;
  logic [3:0]        op_rd;
  logic              op_gpr_we;
  logic              op_store;
  logic              op_load;
  logic [1:0]        op_lsize;
  logic              op_unsigned;
  logic [DATA_W-1:0] op_result;

  logic              accept;
  logic              in_mem;
  logic              req_misaligned;
  logic [3:0]        req_wstrb;
  logic [31:0]       req_wdata_lanes;
  logic [31:0]       ld_value;
  logic              issue_req;
  logic              pass_done;
  logic              resp_done;
  logic              wd_expire;
  logic              timeout_done;

  assign lsu_ready    = (state == ST_IDLE) && (!lsu_valid || wbu_ready);
  assign accept       = exu_valid && lsu_ready;
  assign in_mem       = in_is_read || in_is_write;
  assign issue_req    = accept && in_mem && !req_misaligned;
  assign pass_done    = accept && (!in_mem || req_misaligned);
  assign resp_done    = (state == ST_WAIT) && mem_resp_valid;
  assign wd_expire    = WD_EN && (wd_cnt == WD_LIMIT);
  assign timeout_done = (state == ST_WAIT) && !mem_resp_valid && wd_expire;

  ysyx_25020037_lsu_align u_align (
    .req_is_write    (in_is_write),
    .req_lsize       (in_lsize),
    .req_ssize       (in_ssize),
    .req_lane        (in_result[1:0]),
    .req_wdata       (in_wdata),
    .req_misaligned  (req_misaligned),
    .req_wstrb       (req_wstrb),
    .req_wdata_lanes (req_wdata_lanes),
    .ld_size         (op_lsize),
    .ld_lane         (op_result[1:0]),
    .ld_unsigned     (op_unsigned),
    .ld_rdata        (mem_rdata),
    .ld_value        (ld_value)
  );

  // Controller: request issue/hold, response wait with watchdog, late-response drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      wd_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_req) begin
            state         <= ST_REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= in_is_write;
            mem_addr      <= {in_result[ADDR_W-1:2], 2'b00};
            mem_wdata     <= req_wdata_lanes;
            mem_wstrb     <= in_is_write ? req_wstrb : 4'b0000;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
            wd_cnt        <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state <= ST_IDLE;
          end else if (wd_expire) begin
            state <= ST_DRAIN;
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          // the abandoned response still has to come back before reuse
          if (mem_resp_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the accepted op for completion after the memory round trip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_pc       <= '0;
      op_rd       <= '0;
      op_gpr_we   <= 1'b0;
      op_store    <= 1'b0;
      op_load     <= 1'b0;
      op_lsize    <= SZ_NONE;
      op_unsigned <= 1'b0;
      op_result   <= '0;
    end else if (accept) begin
      op_pc       <= in_pc;
      op_rd       <= in_rd;
      op_gpr_we   <= in_gpr_we;
      op_store    <= in_is_write;
      op_load     <= in_is_read && !in_is_write;
      op_lsize    <= in_lsize;
      op_unsigned <= in_unsigned;
      op_result   <= in_result;
    end
  end

  // Write-back output register: load on any completion, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_valid       <= 1'b0;
      lsu_pc          <= '0;
      lsu_rd          <= '0;
      lsu_gpr_we      <= 1'b0;
      lsu_wdata       <= '0;
      lsu_fault       <= 1'b0;
      rdata_processed <= '0;
    end else begin
      if (pass_done) begin
        // pass-through result, or a misaligned memory op faulting without a request
        lsu_valid  <= 1'b1;
        lsu_pc     <= in_pc;
        lsu_rd     <= in_rd;
        lsu_wdata  <= in_result;
        lsu_fault  <= in_mem;
        lsu_gpr_we <= in_gpr_we && !in_mem;
      end else if (resp_done) begin
        lsu_valid  <= 1'b1;
        lsu_pc     <= op_pc;
        lsu_rd     <= op_rd;
        lsu_fault  <= mem_resp_err;
        lsu_gpr_we <= op_gpr_we && !op_store && !mem_resp_err;
        if (op_load && !mem_resp_err) begin
          lsu_wdata       <= ld_value;
          rdata_processed <= ld_value;
        end else begin
          lsu_wdata <= op_result;
        end
      end else if (timeout_done) begin
        lsu_valid  <= 1'b1;
        lsu_pc     <= op_pc;
        lsu_rd     <= op_rd;
        lsu_wdata  <= op_result;
        lsu_fault  <= 1'b1;
        lsu_gpr_we <= 1'b0;
      end else if (wbu_ready) begin
        lsu_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020037_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25020037_lsu_stage
// Description : Self-checking bench for the load/store stage (watchdog of 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020037_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, lsu_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_rd;
  logic        in_gpr_we, in_is_read, in_is_write, in_unsigned;
  logic [1:0]  in_lsize, in_ssize;
  logic [31:0] in_result, in_wdata, rdata_processed;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic        lsu_valid, wbu_ready, lsu_gpr_we, lsu_fault;
  logic [31:0] lsu_pc, lsu_wdata;
  logic [3:0]  lsu_rd;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rp = 32'h0;

  always #5 clk = ~clk;

  ysyx_25020037_lsu_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_gpr_we(in_gpr_we), .in_is_read(in_is_read),
    .in_is_write(in_is_write), .in_lsize(in_lsize), .in_ssize(in_ssize),
    .in_unsigned(in_unsigned), .in_result(in_result), .in_wdata(in_wdata),
    .rdata_processed(rdata_processed), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err), .lsu_valid(lsu_valid),
    .wbu_ready(wbu_ready), .lsu_pc(lsu_pc), .lsu_rd(lsu_rd), .lsu_gpr_we(lsu_gpr_we),
    .lsu_wdata(lsu_wdata), .lsu_fault(lsu_fault)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                           input int sz, input bit uns);
    longint unsigned v;
    v = longint'(rdata) >> (8 * off);
    if (sz == 1) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store_data(input logic [31:0] d, input int sz);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] ref_strb(input int off, input int sz);
    int s;
    if (sz == 1) s = 1 << off;
    else if (sz == 2) s = 3 << off;
    else s = 15;
    return s[3:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [3:0] rd, input logic gwe,
                          input logic rdf, input logic wrf, input logic [1:0] ls,
                          input logic [1:0] ss, input logic uns, input logic [31:0] res,
                          input logic [31:0] wd);
    exu_valid = 1'b1; in_pc = pc; in_rd = rd; in_gpr_we = gwe; in_is_read = rdf;
    in_is_write = wrf; in_lsize = ls; in_ssize = ss; in_unsigned = uns;
    in_result = res; in_wdata = wd;
  endtask

  // Waits (bounded) for a request, handshakes it, then responds after lat cycles
  task automatic serve_mem(input int lat, input logic [31:0] rdata, input logic err,
                           output logic we, output logic [31:0] addr,
                           output logic [31:0] wd, output logic [3:0] strb, output bit tmo);
    int n;
    n = 0; tmo = 1'b0;
    while (!mem_req_valid && n < 50) begin tick(); n++; end
    if (!mem_req_valid) begin tmo = 1'b1; return; end
    we = mem_req_we; addr = mem_addr; wd = mem_wdata; strb = mem_wstrb;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (lat) tick();
    mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = err;
    tick();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({lsu_valid, mem_req_valid, lsu_fault, lsu_gpr_we, lsu_rd, lsu_pc, lsu_wdata, rdata_processed} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b req=%b fault=%b gwe=%b rd=%h pc=%h wdata=%h rp=%h expected all zero",
               lsu_valid, mem_req_valid, lsu_fault, lsu_gpr_we, lsu_rd, lsu_pc, lsu_wdata, rdata_processed);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", lsu_ready); end
  endtask

  task automatic test_passthrough();
    drive_op(32'h8000_0000, 4'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h1234, 32'h0);
    tick();
    exu_valid = 1'b0;
    checks++;
    if ({lsu_valid, lsu_fault, lsu_gpr_we} !== 3'b101 || lsu_wdata !== 32'h1234 || lsu_rd !== 4'd5 || lsu_pc !== 32'h8000_0000) begin
      failures++;
      $display("FAIL pass_single: v/f/we=%b%b%b wdata=%h rd=%0d pc=%h expected 101 00001234 5 80000000",
               lsu_valid, lsu_fault, lsu_gpr_we, lsu_wdata, lsu_rd, lsu_pc);
    end
    tick();
    checks++;
    if (lsu_valid !== 1'b0) begin failures++; $display("FAIL pass_drop: lsu_valid=%b expected 0", lsu_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_op(32'h8000_0100 + 4 * i, 4'(i + 1), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'hA000 + i, 32'h0);
      tick();
      checks++;
      if (lsu_valid !== 1'b1 || lsu_wdata !== 32'hA000 + i || lsu_rd !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%b wdata=%h rd=%0d expected 1 %h %0d", i, lsu_valid, lsu_wdata, lsu_rd, 32'hA000 + i, i + 1);
      end
    end
    exu_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    logic we; logic [31:0] a, wd; logic [3:0] st; bit tmo;
    for (int u = 0; u < 2; u++) begin
      drive_op(32'h8000_0200, 4'd7, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, u[0], 32'h8000_0003, 32'h0);
      tick();
      exu_valid = 1'b0;
      serve_mem(1, 32'h80FF_EE11, 1'b0, we, a, wd, st, tmo);
      exp_rp = u ? 32'h0000_0080 : 32'hFFFF_FF80;
      checks++;
      if (tmo || we !== 1'b0 || a !== 32'h8000_0000) begin
        failures++; $display("FAIL lb_req_%0d: tmo=%0d we=%b addr=%h expected 0 0 80000000", u, tmo, we, a);
      end
      checks++;
      if (lsu_valid !== 1'b1 || lsu_wdata !== exp_rp || rdata_processed !== exp_rp || lsu_gpr_we !== 1'b1 || lsu_fault !== 1'b0) begin
        failures++;
        $display("FAIL lb_result_%0d: valid=%b wdata=%h rp=%h gwe=%b fault=%b expected 1 %h %h 1 0",
                 u, lsu_valid, lsu_wdata, rdata_processed, lsu_gpr_we, lsu_fault, exp_rp, exp_rp);
      end
    end
  endtask

  task automatic test_store_half();
    logic we; logic [31:0] a, wd; logic [3:0] st; bit tmo;
    drive_op(32'h8000_0300, 4'd9, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 32'h8000_0012, 32'h0000_ABCD);
    tick();
    exu_valid = 1'b0;
    serve_mem(0, 32'h0, 1'b0, we, a, wd, st, tmo);
    checks++;
    if (tmo || we !== 1'b1 || a !== 32'h8000_0010 || wd !== 32'hABCD_ABCD || st !== 4'b1100) begin
      failures++;
      $display("FAIL sh_req: tmo=%0d we=%b addr=%h wdata=%h strb=%b expected 0 1 80000010 abcdabcd 1100", tmo, we, a, wd, st);
    end
    checks++;
    if (lsu_valid !== 1'b1 || lsu_gpr_we !== 1'b0 || lsu_fault !== 1'b0 || rdata_processed !== exp_rp) begin
      failures++;
      $display("FAIL sh_result: valid=%b gwe=%b fault=%b rp=%h expected 1 0 0 %h", lsu_valid, lsu_gpr_we, lsu_fault, rdata_processed, exp_rp);
    end
  endtask

  task automatic test_misaligned();
    drive_op(32'h8000_0400, 4'd3, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h8000_0006, 32'h0);
    tick();
    exu_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || lsu_valid !== 1'b1 || lsu_fault !== 1'b1 || lsu_gpr_we !== 1'b0) begin
      failures++;
      $display("FAIL lw_misaligned: req=%b valid=%b fault=%b gwe=%b expected 0 1 1 0", mem_req_valid, lsu_valid, lsu_fault, lsu_gpr_we);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b0 || lsu_valid !== 1'b0) begin
      failures++; $display("FAIL lw_misaligned_after: req=%b valid=%b expected 0 0", mem_req_valid, lsu_valid);
    end
  endtask

  task automatic test_req_stall();
    logic we; logic [31:0] a, wd; logic [3:0] st; bit tmo;
    int bad;
    bad = 0;
    drive_op(32'h8000_0500, 4'd4, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h8000_0104, 32'h0);
    tick();
    // a second op is presented throughout and must not be taken
    drive_op(32'h8000_0504, 4'd6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'hDEAD, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_addr !== 32'h8000_0104 || lsu_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL req_stall: %0d unstable cycles, last req=%b addr=%h ready=%b expected 0", bad, mem_req_valid, mem_addr, lsu_ready);
    end
    exu_valid = 1'b0;
    serve_mem(2, 32'h1357_9BDF, 1'b0, we, a, wd, st, tmo);
    exp_rp = 32'h1357_9BDF;
    checks++;
    if (tmo || lsu_valid !== 1'b1 || lsu_wdata !== exp_rp || lsu_rd !== 4'd4 || lsu_pc !== 32'h8000_0500) begin
      failures++;
      $display("FAIL req_stall_result: tmo=%0d valid=%b wdata=%h rd=%0d pc=%h expected 0 1 %h 4 80000500", tmo, lsu_valid, lsu_wdata, lsu_rd, lsu_pc, exp_rp);
    end
  endtask

  task automatic test_timeout();
    int n, bad;
    bad = 0;
    drive_op(32'h8000_0600, 4'd8, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h8000_0200, 32'h0);
    tick();
    exu_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n = 0;
    while (n < 30) begin
      tick(); n++;
      if (lsu_valid) break;
    end
    checks++;
    if (n != 8 || lsu_valid !== 1'b1) begin
      failures++; $display("FAIL timeout_cycle: fault after %0d wait cycles valid=%b expected 8 1", n, lsu_valid);
    end
    checks++;
    if (lsu_fault !== 1'b1 || lsu_gpr_we !== 1'b0 || lsu_ready !== 1'b0 || lsu_rd !== 4'd8) begin
      failures++;
      $display("FAIL timeout_fault: fault=%b gwe=%b ready=%b rd=%0d expected 1 0 0 8", lsu_fault, lsu_gpr_we, lsu_ready, lsu_rd);
    end
    while (n < 19) begin
      tick(); n++;
      if (lsu_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL drain_ready: %0d cycles with lsu_ready=1 expected 0", bad); end
    mem_resp_valid = 1'b1; mem_rdata = 32'hFACE_FACE;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (lsu_ready !== 1'b1 || lsu_valid !== 1'b0 || rdata_processed !== exp_rp) begin
      failures++;
      $display("FAIL drain_exit: ready=%b valid=%b rp=%h expected 1 0 %h", lsu_ready, lsu_valid, rdata_processed, exp_rp);
    end
  endtask

  task automatic test_output_hold();
    logic we; logic [31:0] a, wd; logic [3:0] st; bit tmo;
    int bad;
    bad = 0;
    drive_op(32'h8000_0700, 4'd11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 32'h8000_0302, 32'h0);
    tick();
    exu_valid = 1'b0;
    wbu_ready = 1'b0;
    serve_mem(0, 32'hC001_7777, 1'b0, we, a, wd, st, tmo);
    exp_rp = 32'h0000_C001;
    drive_op(32'h8000_0704, 4'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h5555, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (lsu_ready !== 1'b0 || lsu_valid !== 1'b1 || lsu_wdata !== exp_rp || lsu_rd !== 4'd11 ||
          lsu_pc !== 32'h8000_0700 || lsu_gpr_we !== 1'b1 || lsu_fault !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (tmo || bad != 0) begin
      failures++;
      $display("FAIL output_hold: tmo=%0d %0d unstable cycles wdata=%h rd=%0d ready=%b expected %h 11 0", tmo, bad, lsu_wdata, lsu_rd, lsu_ready, exp_rp);
    end
    wbu_ready = 1'b1;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin failures++; $display("FAIL handoff_ready: got %b expected 1", lsu_ready); end
    tick();
    exu_valid = 1'b0;
    checks++;
    if (lsu_valid !== 1'b1 || lsu_wdata !== 32'h5555 || lsu_rd !== 4'd12 || rdata_processed !== exp_rp) begin
      failures++;
      $display("FAIL handoff_result: valid=%b wdata=%h rd=%0d rp=%h expected 1 00005555 12 %h", lsu_valid, lsu_wdata, lsu_rd, rdata_processed, exp_rp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_op(32'h8000_0800, 4'd13, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h8000_0400, 32'h0);
    tick();
    exu_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_rp = 32'h0;
    checks++;
    if ({lsu_valid, mem_req_valid, lsu_fault, lsu_gpr_we, lsu_rd, lsu_pc, lsu_wdata, rdata_processed} !== '0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b req=%b fault=%b gwe=%b rd=%h pc=%h wdata=%h rp=%h expected all zero",
               lsu_valid, mem_req_valid, lsu_fault, lsu_gpr_we, lsu_rd, lsu_pc, lsu_wdata, rdata_processed);
    end
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (lsu_valid !== 1'b0 || lsu_ready !== 1'b1 || rdata_processed !== 32'h0) begin
      failures++;
      $display("FAIL stale_resp: valid=%b ready=%b rp=%h expected 0 1 0", lsu_valid, lsu_ready, rdata_processed);
    end
  endtask

  task automatic test_random();
    logic we; logic [31:0] a, wd; logic [3:0] st; bit tmo;
    int kind, sz, off, lat;
    bit misal, err, fault_e, gwe_e, gwe, rdf, wrf, uns;
    logic [31:0] addr, res_e, rdata, sdata, pc;
    logic [3:0] rd;
    for (int i = 0; i < 150; i++) begin
      kind  = $urandom_range(0, 2);
      sz    = $urandom_range(1, 3);
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) addr = (sz == 3) ? (addr & ~32'h3) : (sz == 2) ? (addr & ~32'h1) : addr;
      off   = addr[1:0];
      misal = (kind != 0) && ((sz == 2 && off % 2 != 0) || (sz == 3 && off != 0));
      gwe   = $urandom_range(0, 1);
      uns   = $urandom_range(0, 1);
      err   = ($urandom_range(0, 7) == 0);
      lat   = $urandom_range(0, 4);
      rdata = $urandom;
      sdata = $urandom;
      pc    = $urandom;
      rd    = 4'($urandom_range(0, 15));
      wrf   = (kind == 2);
      rdf   = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      drive_op(pc, rd, gwe, rdf, wrf, (kind == 1) ? 2'(sz) : 2'b00, (kind == 2) ? 2'(sz) : 2'b00, uns, addr, sdata);
      #1;
      checks++;
      if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready_%0d: got %b expected 1", i, lsu_ready); end
      tick();
      exu_valid = 1'b0;
      if (kind != 0 && !misal) begin
        serve_mem(lat, rdata, err, we, a, wd, st, tmo);
        checks++;
        if (tmo || we !== wrf || a !== {addr[31:2], 2'b00} ||
            (wrf && (st !== ref_strb(off, sz) || wd !== ref_store_data(sdata, sz)))) begin
          failures++;
          $display("FAIL rnd_req_%0d: tmo=%0d we=%b addr=%h wdata=%h strb=%b expected %b %h %h %b",
                   i, tmo, we, a, wd, st, wrf, {addr[31:2], 2'b00}, ref_store_data(sdata, sz), ref_strb(off, sz));
        end
      end else begin
        checks++;
        if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rnd_noreq_%0d: req=%b expected 0", i, mem_req_valid); end
      end
      fault_e = misal || (kind != 0 && err);
      gwe_e   = gwe && (kind != 2) && !fault_e;
      res_e   = (kind == 1) ? ref_load(rdata, off, sz, uns) : addr;
      if (kind == 1 && !fault_e) exp_rp = res_e;
      checks++;
      if (lsu_valid !== 1'b1 || lsu_fault !== fault_e || lsu_gpr_we !== gwe_e || lsu_pc !== pc ||
          lsu_rd !== rd || (!fault_e && lsu_wdata !== res_e) || rdata_processed !== exp_rp) begin
        failures++;
        $display("FAIL rnd_out_%0d: kind=%0d valid=%b fault=%b gwe=%b pc=%h rd=%0d wdata=%h rp=%h expected 1 %b %b %h %0d %h %h",
                 i, kind, lsu_valid, lsu_fault, lsu_gpr_we, lsu_pc, lsu_rd, lsu_wdata, rdata_processed,
                 fault_e, gwe_e, pc, rd, res_e, exp_rp);
      end
    end
    tick();
  endtask

  initial begin
    exu_valid = 1'b0; in_pc = '0; in_rd = '0; in_gpr_we = 1'b0; in_is_read = 1'b0;
    in_is_write = 1'b0; in_lsize = 2'b00; in_ssize = 2'b00; in_unsigned = 1'b0;
    in_result = '0; in_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; mem_resp_err = 1'b0; wbu_ready = 1'b1;
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_req_stall();
    test_timeout();
    test_output_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
